// File: rtl/dap_baud_pkg.sv
// dap_baud_pkg: shared definitions for the DAP baud generator register window.
// Holds the generator register offsets, the TIMING field layout, the
// sequencer state encoding (also reused by the generator and its drivers),
// and helpers that build the register words.
package dap_baud_pkg;

  localparam int CR_OFS     = 0;
  localparam int TIMING_OFS = 4;

  localparam int CR_CEN_BIT = 0;

  localparam int DIV_LSB        = 0;
  localparam int DIV_MSB        = 15;
  localparam int DELAY_LSB      = 16;
  localparam int DELAY_MSB      = 18;
  localparam int TIMING_FIELD_W = DELAY_MSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_STOP       = 3'd1,
    ST_STOP_WAIT  = 3'd2,
    ST_WR_TIMING  = 3'd3,
    ST_RD_TIMING  = 3'd4,
    ST_START      = 3'd5,
    ST_START_WAIT = 3'd6,
    ST_DONE       = 3'd7
  } baud_state_e;

  function automatic logic [31:0] pack_timing(input logic [15:0] div,
                                              input logic [2:0]  delay);
    logic [31:0] w;
    w = '0;
    w[DIV_MSB:DIV_LSB]     = div;
    w[DELAY_MSB:DELAY_LSB] = delay;
    return w;
  endfunction

  function automatic logic [31:0] cr_word(input logic cen);
    logic [31:0] w;
    w = '0;
    w[CR_CEN_BIT] = cen;
    return w;
  endfunction

endpackage

// File: rtl/dap_rr_arb2.sv
// dap_rr_arb2: two-way round-robin arbiter.
// Ports:
//   clk, resetn  - clock, async active-low reset
//   valid[1:0]   - request lines
//   advance      - one-cycle pulse when the served requester completes
//   served_idx   - index of the requester that just completed
//   grant[1:0]   - one-hot combinational grant (zero when nothing is valid)
// After reset last_grant is 1, so requester 0 wins the first contest.
module dap_rr_arb2
  import dap_baud_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] valid,
  input  logic       advance,
  input  logic       served_idx,
  output logic [1:0] grant
);

  logic last_grant;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= served_idx;
    end
  end

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant = 2'b00;
    if (valid[0] && (!valid[1] || last_grant)) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dap_baud_ctrl.sv
// dap_baud_ctrl: configuration sequencer and arbiter for the DAP baud
// generator register window. Serialises retime/start/stop requests from two
// requesters and drives the generator slave through the safe sequence
// stop -> settle -> program TIMING -> read back -> start -> settle -> done.
// Ports:
//   clk, resetn              - clock, async active-low reset
//   req_valid/req_start[1:0] - per-requester request and op (1 = enable)
//   req_div0/1, req_delay0/1 - per-requester divider and sample-delay tap
//   req_done[1:0], req_err   - one-cycle completion pulse and readback error
//   busy                     - high from grant through done
//   gen_*                    - register-bus master toward the generator
//
// state         | meaning
// --------------+----------------------------------------------------
// ST_IDLE       | waiting for a request; arbitrate and latch payload
// ST_STOP       | CR = 0 write on the bus; load settle timer
// ST_STOP_WAIT  | settle after stop; then program or finish
// ST_WR_TIMING  | TIMING write on the bus
// ST_RD_TIMING  | TIMING read on the bus; compare with payload
// ST_START      | CR = 1 write on the bus; load settle timer
// ST_START_WAIT | settle after start
// ST_DONE       | done/err pulse; advance arbiter; drop busy
module dap_baud_ctrl
  import dap_baud_pkg::*;
#(
  parameter int ADDRWIDTH     = 12,
  parameter int GEN_BASE_ADDR = 0,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [1:0]           req_valid,
  input  logic [1:0]           req_start,
  input  logic [15:0]          req_div0,
  input  logic [15:0]          req_div1,
  input  logic [2:0]           req_delay0,
  input  logic [2:0]           req_delay1,
  output logic [1:0]           req_done,
  output logic                 req_err,
  output logic                 busy,
  output logic                 gen_write_en,
  output logic                 gen_read_en,
  output logic [ADDRWIDTH-1:0] gen_addr,
  output logic [31:0]          gen_wdata,
  output logic [3:0]           gen_byte_strobe,
  input  logic [31:0]          gen_rdata
);

  localparam logic [ADDRWIDTH-1:0] CR_ADDR     = ADDRWIDTH'(GEN_BASE_ADDR + CR_OFS);
  localparam logic [ADDRWIDTH-1:0] TIMING_ADDR = ADDRWIDTH'(GEN_BASE_ADDR + TIMING_OFS);
  localparam logic [7:0]           SETTLE_LOAD = 8'(SETTLE_CYCLES);

  baud_state_e state;
  logic [7:0]  settle_cnt;
  logic [1:0]  lat_grant;
  logic        lat_start;
  logic [15:0] lat_div;
  logic [2:0]  lat_delay;

  logic [1:0]  grant;
  logic        advance;
  logic        readback_bad;
  logic        unused_rdata_hi;

  assign advance         = (state == ST_DONE);
  assign readback_bad    = gen_rdata[TIMING_FIELD_W-1:0] != {lat_delay, lat_div};
  assign unused_rdata_hi = ^gen_rdata[31:TIMING_FIELD_W];

  dap_rr_arb2 u_arb (
    .clk        (clk),
    .resetn     (resetn),
    .valid      (req_valid),
    .advance    (advance),
    .served_idx (lat_grant[1]),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      settle_cnt      <= '0;
      lat_grant       <= '0;
      lat_start       <= 1'b0;
      lat_div         <= '0;
      lat_delay       <= '0;
      busy            <= 1'b0;
      req_done        <= '0;
      req_err         <= 1'b0;
      gen_write_en    <= 1'b0;
      gen_read_en     <= 1'b0;
      gen_addr        <= '0;
      gen_wdata       <= '0;
      gen_byte_strobe <= '0;
    end else begin
      // Bus accesses and the done pulse are issued on entry to a state and
      // last exactly that one cycle, so they default back to idle here.
      gen_write_en    <= 1'b0;
      gen_read_en     <= 1'b0;
      gen_addr        <= '0;
      gen_wdata       <= '0;
      gen_byte_strobe <= '0;
      req_done        <= '0;
      req_err         <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (|grant) begin
            lat_grant       <= grant;
            lat_start       <= grant[1] ? req_start[1] : req_start[0];
            lat_div         <= grant[1] ? req_div1     : req_div0;
            lat_delay       <= grant[1] ? req_delay1   : req_delay0;
            busy            <= 1'b1;
            state           <= ST_STOP;
            gen_write_en    <= 1'b1;
            gen_addr        <= CR_ADDR;
            gen_wdata       <= cr_word(1'b0);
            gen_byte_strobe <= 4'hF;
          end
        end

        ST_STOP: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= ST_STOP_WAIT;
        end

        // Timer is loaded with SETTLE_CYCLES and leaves on terminal count 1,
        // giving exactly SETTLE_CYCLES cycles in the wait state.
        ST_STOP_WAIT: begin
          settle_cnt <= settle_cnt - 8'd1;
          if (settle_cnt == 8'd1) begin
            if (lat_start) begin
              state           <= ST_WR_TIMING;
              gen_write_en    <= 1'b1;
              gen_addr        <= TIMING_ADDR;
              gen_wdata       <= pack_timing(lat_div, lat_delay);
              gen_byte_strobe <= 4'hF;
            end else begin
              state    <= ST_DONE;
              req_done <= lat_grant;
            end
          end
        end

        ST_WR_TIMING: begin
          state       <= ST_RD_TIMING;
          gen_read_en <= 1'b1;
          gen_addr    <= TIMING_ADDR;
        end

        // gen_rdata is valid in this cycle because the read strobe is live.
        ST_RD_TIMING: begin
          if (readback_bad) begin
            state    <= ST_DONE;
            req_done <= lat_grant;
            req_err  <= 1'b1;
          end else begin
            state           <= ST_START;
            gen_write_en    <= 1'b1;
            gen_addr        <= CR_ADDR;
            gen_wdata       <= cr_word(1'b1);
            gen_byte_strobe <= 4'hF;
          end
        end

        ST_START: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= ST_START_WAIT;
        end

        ST_START_WAIT: begin
          settle_cnt <= settle_cnt - 8'd1;
          if (settle_cnt == 8'd1) begin
            state    <= ST_DONE;
            req_done <= lat_grant;
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dap_baud_ctrl.sv
// tb_dap_baud_ctrl: self-checking bench for dap_baud_ctrl.
// A behavioural generator register slave answers the bus. An op-level model
// predicts, at issue time, every bus access and done pulse (with its cycle);
// a monitor pops and compares them whenever the DUT presents one.
module tb_dap_baud_ctrl;

  localparam int AW   = 12;
  localparam int BASE = 'h40;
  localparam int S    = 8;
  localparam logic [AW-1:0] A_CR  = AW'(BASE);
  localparam logic [AW-1:0] A_TIM = AW'(BASE + 4);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [1:0]    req_valid;
  logic [1:0]    req_start;
  logic [15:0]   req_div0, req_div1;
  logic [2:0]    req_delay0, req_delay1;
  logic [1:0]    req_done;
  logic          req_err, busy;
  logic          gen_write_en, gen_read_en;
  logic [AW-1:0] gen_addr;
  logic [31:0]   gen_wdata;
  logic [3:0]    gen_byte_strobe;
  logic [31:0]   gen_rdata;

  always #5 clk = ~clk;

  dap_baud_ctrl #(.ADDRWIDTH(AW), .GEN_BASE_ADDR(BASE), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_start(req_start),
    .req_div0(req_div0), .req_div1(req_div1),
    .req_delay0(req_delay0), .req_delay1(req_delay1),
    .req_done(req_done), .req_err(req_err), .busy(busy),
    .gen_write_en(gen_write_en), .gen_read_en(gen_read_en),
    .gen_addr(gen_addr), .gen_wdata(gen_wdata),
    .gen_byte_strobe(gen_byte_strobe), .gen_rdata(gen_rdata)
  );

  // Generator register slave; shares resetn and comes up disabled.
  logic [31:0] gen_cr, gen_tim;
  bit          fault_en = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gen_cr  <= 32'd0;
      gen_tim <= 32'd0;
    end else if (gen_write_en) begin
      if (gen_addr == A_CR) gen_cr <= gen_wdata;
      else if (gen_addr == A_TIM) gen_tim <= gen_wdata;
    end
  end

  always_comb begin
    gen_rdata = 32'd0;
    if (gen_read_en) begin
      if (gen_addr == A_TIM) gen_rdata = gen_tim;
      else if (gen_addr == A_CR) gen_rdata = gen_cr;
      if (fault_en) gen_rdata[18:0] = 19'h00001;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic start; logic [15:0] div; logic [2:0] dly; } op_t;
  typedef struct { int cyc; logic wr; logic [AW-1:0] addr; logic [31:0] data; } bus_t;
  typedef struct { int cyc; logic [1:0] done; logic err; } done_t;

  op_t   pend0[$], pend1[$];
  bus_t  exp_bus[$];
  done_t exp_done[$];
  int    model_last = 1;
  bit    model_cen  = 1'b0;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] got);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, got, cyc);
  endtask

  // ---------------- reference model (op level) ----------------
  task automatic push_bus(input int c, input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    bus_t b;
    b.cyc = c; b.wr = wr; b.addr = a; b.data = d;
    exp_bus.push_back(b);
  endtask

  // n = the cycle in which the request is granted (the IDLE cycle).
  task automatic plan_op(input int who, input op_t o, input int n, output int done_cyc);
    done_t   d;
    logic    err;
    logic [18:0] fld;
    fld = {o.dly, o.div};
    err = 1'b0;
    push_bus(n + 1, 1'b1, A_CR, 32'd0);
    if (!o.start) begin
      done_cyc  = n + S + 2;
      model_cen = 1'b0;
    end else begin
      push_bus(n + S + 2, 1'b1, A_TIM, {13'd0, o.dly, o.div});
      push_bus(n + S + 3, 1'b0, A_TIM, 32'd0);
      if (fault_en && fld != 19'h00001) begin
        done_cyc  = n + S + 4;
        err       = 1'b1;
        model_cen = 1'b0;
      end else begin
        push_bus(n + S + 4, 1'b1, A_CR, 32'd1);
        done_cyc  = n + 2 * S + 5;
        model_cen = 1'b1;
      end
    end
    d.cyc = done_cyc; d.done = (who == 0) ? 2'b01 : 2'b10; d.err = err;
    exp_done.push_back(d);
  endtask

  // Round-robin over the pending ops: a lone requester wins, a tie goes to
  // the one not served last; the next grant follows the previous done.
  task automatic plan_batch(input int n0);
    int i0, i1, n, d, who;
    i0 = 0; i1 = 0; n = n0;
    while (i0 < pend0.size() || i1 < pend1.size()) begin
      if (i0 < pend0.size() && i1 < pend1.size()) who = (model_last == 0) ? 1 : 0;
      else who = (i0 < pend0.size()) ? 0 : 1;
      if (who == 0) begin plan_op(0, pend0[i0], n, d); i0++; end
      else          begin plan_op(1, pend1[i1], n, d); i1++; end
      model_last = who;
      n = d + 1;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bus_t  b;
    done_t d;
    if (resetn) begin
      if (gen_write_en && gen_read_en) fail_now("wr_rd_overlap", {30'd0, gen_write_en, gen_read_en});
      if (gen_write_en || gen_read_en) begin
        if (exp_bus.size() == 0) begin
          fail_now("unexpected_access", {19'd0, gen_write_en, gen_addr});
        end else begin
          b = exp_bus.pop_front();
          chk("bus_cycle", cyc, b.cyc);
          chk("bus_is_write", {31'd0, gen_write_en}, {31'd0, b.wr});
          chk("bus_addr", {20'd0, gen_addr}, {20'd0, b.addr});
          chk("bus_strobe", {28'd0, gen_byte_strobe}, b.wr ? 32'hF : 32'h0);
          if (b.wr) chk("bus_wdata", gen_wdata, b.data);
        end
      end
      if (req_done != 2'b00) begin
        if (exp_done.size() == 0) begin
          fail_now("unexpected_done", {30'd0, req_done});
        end else begin
          d = exp_done.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_vec", {30'd0, req_done}, {30'd0, d.done});
          chk("done_err", {31'd0, req_err}, {31'd0, d.err});
        end
      end
    end
  end

  // ---------------- driver ----------------
  function automatic op_t mk(input logic st, input logic [15:0] dv, input logic [2:0] dl);
    op_t o;
    o.start = st; o.div = dv; o.dly = dl;
    return o;
  endfunction

  function automatic op_t rnd_op(input logic st);
    op_t o;
    o.start = st;
    o.div   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
    o.dly   = 3'($urandom);
    return o;
  endfunction

  task automatic present(input int i);
    if (i == 0) begin
      if (pend0.size() > 0) begin
        req_valid[0] = 1'b1; req_start[0] = pend0[0].start;
        req_div0 = pend0[0].div; req_delay0 = pend0[0].dly;
      end else begin
        req_valid[0] = 1'b0; req_start[0] = 1'($urandom);
        req_div0 = 16'($urandom); req_delay0 = 3'($urandom);
      end
    end else begin
      if (pend1.size() > 0) begin
        req_valid[1] = 1'b1; req_start[1] = pend1[0].start;
        req_div1 = pend1[0].div; req_delay1 = pend1[0].dly;
      end else begin
        req_valid[1] = 1'b0; req_start[1] = 1'($urandom);
        req_div1 = 16'($urandom); req_delay1 = 3'($urandom);
      end
    end
  endtask

  task automatic clear_model();
    pend0.delete(); pend1.delete(); exp_bus.delete(); exp_done.delete();
    model_last = 1; model_cen = 1'b0;
  endtask

  // drop_after > 0: requester 0 drops valid and scrambles its payload that
  // many cycles after the batch's first grant.
  task automatic run_batch(input bit fault, input int drop_after);
    int n, guard;
    @(negedge clk);
    fault_en = fault;
    n = cyc;
    plan_batch(n);
    present(0);
    present(1);
    guard = 0;
    while ((pend0.size() + pend1.size()) > 0 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (drop_after > 0 && cyc == n + drop_after) begin
        req_valid[0] = 1'b0; req_start[0] = ~req_start[0];
        req_div0 = 16'($urandom); req_delay0 = 3'($urandom);
      end
      if (req_done[0] && pend0.size() > 0) begin pend0.delete(0); present(0); end
      if (req_done[1] && pend1.size() > 0) begin pend1.delete(0); present(1); end
    end
    if (guard >= 400) begin
      fail_now("batch_timeout", guard);
      pend0.delete(); pend1.delete();
      req_valid = 2'b00;
    end
    repeat (3) @(negedge clk);
    chk("done_queue_drained", exp_done.size(), 0);
    chk("bus_queue_drained", exp_bus.size(), 0);
    chk("gen_cen", {31'd0, gen_cr[0]}, {31'd0, model_cen});
    chk("busy_after_batch", {31'd0, busy}, 0);
    exp_done.delete(); exp_bus.delete();
    fault_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {30'd0, req_done}, 0);
    chk({tag, "_err"}, {31'd0, req_err}, 0);
    chk({tag, "_wr"}, {31'd0, gen_write_en}, 0);
    chk({tag, "_rd"}, {31'd0, gen_read_en}, 0);
    chk({tag, "_addr"}, {20'd0, gen_addr}, 0);
    chk({tag, "_wdata"}, gen_wdata, 0);
    chk({tag, "_strobe"}, {28'd0, gen_byte_strobe}, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    req_valid = 2'b00;
    clear_model();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_mid_op();
    int n;
    @(negedge clk);
    n = cyc;
    pend0.push_back(rnd_op(1'b1));
    plan_batch(n);
    present(0);
    while (cyc < n + 4) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 1);
    resetn = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    req_valid = 2'b00;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_idle", {31'd0, busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    req_valid = 2'b00; req_start = 2'b00;
    req_div0 = '0; req_div1 = '0; req_delay0 = '0; req_delay1 = '0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // First enable from reset: div 4, delay 3.
    pend0.push_back(mk(1'b1, 16'h0004, 3'd3));
    run_batch(1'b0, 0);
    chk("gen_timing_reg", gen_tim, 32'h0003_0004);

    // Both valid from reset, two ops each: grants 0,1,0,1.
    apply_reset();
    pend0.push_back(rnd_op(1'b1)); pend0.push_back(rnd_op(1'b1));
    pend1.push_back(rnd_op(1'b1)); pend1.push_back(rnd_op(1'b0));
    run_batch(1'b0, 0);

    // Disable op on requester 1 while the clock is running.
    pend1.push_back(rnd_op(1'b1));
    run_batch(1'b0, 0);
    pend1.push_back(rnd_op(1'b0));
    run_batch(1'b0, 0);

    // Readback fault: error reported, clock left disabled.
    pend0.push_back(mk(1'b1, 16'h1234, 3'd5));
    run_batch(1'b1, 0);

    // Requester 0 drops valid three cycles after grant.
    pend0.push_back(rnd_op(1'b1));
    run_batch(1'b0, 3);

    // Reset during STOP_WAIT, then a fresh request (div 0 is legal).
    reset_mid_op();
    pend0.push_back(mk(1'b1, 16'h0000, 3'd7));
    run_batch(1'b0, 0);

    // Randomised batches.
    for (int k = 0; k < 10; k++) begin
      c0 = $urandom_range(0, 2);
      c1 = $urandom_range(0, 2);
      if (c0 + c1 == 0) c1 = 1;
      for (int j = 0; j < c0; j++) pend0.push_back(rnd_op($urandom_range(0, 3) != 0));
      for (int j = 0; j < c1; j++) pend1.push_back(rnd_op($urandom_range(0, 3) != 0));
      run_batch(1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
